// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding controller.
//   fwd_sel_t    : EX-stage ALU operand source select
//   wait_state_t : data-memory wait FSM states
//   fwd_sel()    : forwarding select for one EX source operand
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wait_state_t;

  // MEM wins over WB; x0 never forwards.
  function automatic fwd_sel_t fwd_sel(
    input logic       reg_write_m,
    input logic [4:0] rd_m,
    input logic       reg_write_w,
    input logic [4:0] rd_w,
    input logic [4:0] rs_e
  );
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e))
      return FWD_MEM;
    else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Free-running performance counter with enable, wraps modulo 2^CNT_W.
//   clk : clock (posedge)
//   rst : asynchronous active-high reset, clears cnt
//   en  : count this cycle
//   cnt : current count
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (en)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard/forwarding controller for a 5-stage pipeline.
// Inputs : ID/EX source regs, EX dest + load/redirect flags, MEM/WB dest + write
//          enables, MEM data-memory request and dmem_ready.
// Outputs: StallF/D/E/M, FlushD/E/W (combinational, sampled by pipeline regs on
//          negedge), ForwardAE/BE, stall_cnt/flush_cnt perf counters, sticky
//          mem_timeout_err.
// clk posedge updates the wait FSM and counters; rst is async active-high.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_addrD,
  input  logic [4:0]       rs2_addrD,
  input  logic [4:0]       rs1_addrE,
  input  logic [4:0]       rs2_addrE,
  input  logic [4:0]       rdE,
  input  logic             MemReadE,
  input  logic             PCSrcE,
  input  logic [4:0]       rdM,
  input  logic             RegWriteM,
  input  logic             MemReqM,
  input  logic             dmem_ready,
  input  logic [4:0]       rdW,
  input  logic             RegWriteW,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout_err
);

  localparam int                WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] TMO = WCW'(MEM_TIMEOUT);
  localparam logic [WCW-1:0] ONE = WCW'(1);

  logic lu;
  logic ms;

  wait_state_t       state, state_nx;
  logic [WCW-1:0]    wait_cnt, wait_cnt_nx;
  logic              err_set;

  assign lu = MemReadE && (rdE != 5'd0) && ((rdE == rs1_addrD) || (rdE == rs2_addrD));
  assign ms = MemReqM && !dmem_ready;

  assign ForwardAE = fwd_sel(RegWriteM, rdM, RegWriteW, rdW, rs1_addrE);
  assign ForwardBE = fwd_sel(RegWriteM, rdM, RegWriteW, rdW, rs2_addrE);

  // Memory wait freezes the whole pipe and masks redirect/load-use; a pending
  // PCSrcE stays in EX and is acted on once the wait clears.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (ms) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lu) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    err_set     = 1'b0;
    unique case (state)
      IDLE: begin
        if (ms) begin
          state_nx    = WAIT;
          wait_cnt_nx = ONE;
        end
      end
      WAIT: begin
        if (ms) begin
          if (wait_cnt == TMO)
            err_set = 1'b1;
          else
            wait_cnt_nx = wait_cnt + ONE;
        end else begin
          state_nx    = IDLE;
          wait_cnt_nx = '0;
        end
      end
      default: begin
        state_nx    = IDLE;
        wait_cnt_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      if (err_set)
        mem_timeout_err <= 1'b1;
    end
  end

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (StallF),
    .cnt (stall_cnt)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .en  (FlushE),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
module tb_hazard_ctrl_unit;

  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] rs1_addrD, rs2_addrD, rs1_addrE, rs2_addrE, rdE, rdM, rdW;
  logic MemReadE, PCSrcE, RegWriteM, MemReqM, dmem_ready, RegWriteW;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic mem_timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rs1_addrD(rs1_addrD), .rs2_addrD(rs2_addrD),
    .rs1_addrE(rs1_addrE), .rs2_addrE(rs2_addrE),
    .rdE(rdE), .MemReadE(MemReadE), .PCSrcE(PCSrcE),
    .rdM(rdM), .RegWriteM(RegWriteM), .MemReqM(MemReqM), .dmem_ready(dmem_ready),
    .rdW(rdW), .RegWriteW(RegWriteW),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .mem_timeout_err(mem_timeout_err)
  );

  typedef struct {
    string      name;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE_i, rdM_i, rdW_i;
    logic       mre, pcs, rwm, mrq, rdy, rww;
    logic [3:0] stall;  // {F,D,E,M}
    logic [2:0] flush;  // {D,E,W}
    logic [1:0] fa, fb;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    rs1_addrD = '0; rs2_addrD = '0; rs1_addrE = '0; rs2_addrE = '0;
    rdE = '0; rdM = '0; rdW = '0;
    MemReadE = 1'b0; PCSrcE = 1'b0; RegWriteM = 1'b0; MemReqM = 1'b0;
    dmem_ready = 1'b1; RegWriteW = 1'b0;
  endtask

  // Advance one posedge and land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle async reset pulse that never straddles a clock edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #2;
    chk({tag, "_rst_stall_cnt"}, 32'(stall_cnt), 32'd0);
    chk({tag, "_rst_flush_cnt"}, 32'(flush_cnt), 32'd0);
    chk({tag, "_rst_err"}, 32'(mem_timeout_err), 32'd0);
    rst = 1'b0;
    #1;
  endtask

  task automatic set_lu();
    MemReadE = 1'b1; rdE = 5'd5; rs1_addrD = 5'd5; rs2_addrD = 5'd1;
  endtask

  task automatic set_ms();
    MemReqM = 1'b1; dmem_ready = 1'b0;
  endtask

  function automatic logic [3:0] stall_vec();
    return {StallF, StallD, StallE, StallM};
  endfunction

  function automatic logic [2:0] flush_vec();
    return {FlushD, FlushE, FlushW};
  endfunction

  initial begin
    //                name        rs1D rs2D rs1E rs2E rdE  rdM  rdW  mre pcs rwm mrq rdy rww  stall    flush   fa     fb
    vecs[0]  = '{"idle",      0,   0,   0,   0,   0,   0,   0,   0,  0,  0,  0,  1,  0,  4'b0000, 3'b000, 2'b00, 2'b00};
    vecs[1]  = '{"fwdA_mem",  0,   0,   7,   2,   0,   7,   0,   0,  0,  1,  0,  1,  0,  4'b0000, 3'b000, 2'b10, 2'b00};
    vecs[2]  = '{"fwd_prio",  0,   0,   7,   7,   0,   7,   7,   0,  0,  1,  0,  1,  1,  4'b0000, 3'b000, 2'b10, 2'b10};
    vecs[3]  = '{"fwdB_wb",   0,   0,   1,   3,   0,   9,   3,   0,  0,  1,  0,  1,  1,  4'b0000, 3'b000, 2'b00, 2'b01};
    vecs[4]  = '{"fwd_x0",    0,   0,   0,   0,   0,   0,   0,   0,  0,  1,  0,  1,  1,  4'b0000, 3'b000, 2'b00, 2'b00};
    vecs[5]  = '{"fwd_nowrM", 0,   0,   7,   0,   0,   7,   7,   0,  0,  0,  0,  1,  1,  4'b0000, 3'b000, 2'b01, 2'b00};
    vecs[6]  = '{"lu_rs1",    5,   1,   0,   0,   5,   0,   0,   1,  0,  0,  0,  1,  0,  4'b1100, 3'b010, 2'b00, 2'b00};
    vecs[7]  = '{"lu_rs2",    2,   5,   0,   0,   5,   0,   0,   1,  0,  0,  0,  1,  0,  4'b1100, 3'b010, 2'b00, 2'b00};
    vecs[8]  = '{"lu_x0",     0,   0,   0,   0,   0,   0,   0,   1,  0,  0,  0,  1,  0,  4'b0000, 3'b000, 2'b00, 2'b00};
    vecs[9]  = '{"pcs_lu",    5,   0,   0,   0,   5,   0,   0,   1,  1,  0,  0,  1,  0,  4'b0000, 3'b110, 2'b00, 2'b00};
    vecs[10] = '{"ms_all",    5,   0,   0,   0,   5,   0,   0,   1,  1,  0,  1,  0,  0,  4'b1111, 3'b001, 2'b00, 2'b00};
    vecs[11] = '{"mem_ready", 0,   0,   0,   0,   0,   0,   0,   0,  0,  0,  1,  1,  0,  4'b0000, 3'b000, 2'b00, 2'b00};
    vecs[12] = '{"no_load",   5,   0,   0,   0,   5,   0,   0,   0,  0,  0,  0,  1,  0,  4'b0000, 3'b000, 2'b00, 2'b00};

    clear_inputs();
    #1;
    do_reset("init");
    chk("init_stall", 32'(stall_vec()), 32'd0);
    chk("init_flush", 32'(flush_vec()), 32'd0);

    // Table-driven combinational checks.
    for (int i = 0; i < 13; i++) begin
      rs1_addrD = vecs[i].rs1D; rs2_addrD = vecs[i].rs2D;
      rs1_addrE = vecs[i].rs1E; rs2_addrE = vecs[i].rs2E;
      rdE = vecs[i].rdE_i; rdM = vecs[i].rdM_i; rdW = vecs[i].rdW_i;
      MemReadE = vecs[i].mre; PCSrcE = vecs[i].pcs; RegWriteM = vecs[i].rwm;
      MemReqM = vecs[i].mrq; dmem_ready = vecs[i].rdy; RegWriteW = vecs[i].rww;
      #1;
      chk({vecs[i].name, "_stall"}, 32'(stall_vec()), 32'(vecs[i].stall));
      chk({vecs[i].name, "_flush"}, 32'(flush_vec()), 32'(vecs[i].flush));
      chk({vecs[i].name, "_fwdA"}, 32'(ForwardAE), 32'(vecs[i].fa));
      chk({vecs[i].name, "_fwdB"}, 32'(ForwardBE), 32'(vecs[i].fb));
      step();
    end

    // T1: load-use bubble, then forward from MEM.
    clear_inputs();
    do_reset("t1");
    set_lu();
    #1;
    chk("t1_bubble_stall", 32'(stall_vec()), 32'b1100);
    chk("t1_bubble_flush", 32'(flush_vec()), 32'b010);
    step();
    clear_inputs();
    rs1_addrE = 5'd5; rdM = 5'd5; RegWriteM = 1'b1;
    #1;
    chk("t1_fwdA", 32'(ForwardAE), 32'b10);
    chk("t1_no_stall", 32'(stall_vec()), 32'b0000);
    chk("t1_stall_cnt", 32'(stall_cnt), 32'd1);
    chk("t1_flush_cnt", 32'(flush_cnt), 32'd1);
    step();

    // T2: redirect overrides load-use.
    clear_inputs();
    do_reset("t2");
    set_lu();
    PCSrcE = 1'b1;
    #1;
    chk("t2_flush", 32'(flush_vec()), 32'b110);
    chk("t2_stallF", 32'(StallF), 32'd0);
    step();
    clear_inputs();
    #1;
    chk("t2_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("t2_stall_cnt", 32'(stall_cnt), 32'd0);

    // T3: three-cycle memory wait.
    clear_inputs();
    do_reset("t3");
    set_ms();
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("t3_stall_c%0d", c), 32'(stall_vec()), 32'b1111);
      chk($sformatf("t3_flush_c%0d", c), 32'(flush_vec()), 32'b001);
      step();
    end
    dmem_ready = 1'b1;
    #1;
    chk("t3_release_stall", 32'(stall_vec()), 32'b0000);
    chk("t3_release_flush", 32'(flush_vec()), 32'b000);
    step();
    chk("t3_stall_cnt", 32'(stall_cnt), 32'd3);
    chk("t3_err", 32'(mem_timeout_err), 32'd0);

    // T4: timeout boundary; err appears on the 17th stalled edge.
    clear_inputs();
    do_reset("t4");
    set_ms();
    for (int c = 0; c < MEM_TIMEOUT; c++) step();
    chk("t4_err_before", 32'(mem_timeout_err), 32'd0);
    step();
    chk("t4_err_set", 32'(mem_timeout_err), 32'd1);
    step();
    dmem_ready = 1'b1;
    step();
    step();
    chk("t4_err_sticky", 32'(mem_timeout_err), 32'd1);
    chk("t4_stall_cnt", 32'(stall_cnt), 32'(MEM_TIMEOUT + 2));
    do_reset("t4_clear");

    // T6: reset mid-WAIT, then wait length restarts from zero.
    clear_inputs();
    set_ms();
    step();
    step();
    chk("t6_pre_stall_cnt", 32'(stall_cnt), 32'd2);
    do_reset("t6_midwait");
    for (int c = 0; c < MEM_TIMEOUT; c++) step();
    chk("t6_no_early_err", 32'(mem_timeout_err), 32'd0);
    clear_inputs();
    step();

    // T6: counter wrap.
    do_reset("t6_wrap");
    set_lu();
    for (int c = 0; c < (1 << CNT_W) - 1; c++) step();
    chk("t6_cnt_max", 32'(stall_cnt), 32'((1 << CNT_W) - 1));
    step();
    chk("t6_cnt_wrap", 32'(stall_cnt), 32'd0);
    chk("t6_flush_wrap", 32'(flush_cnt), 32'd0);
    clear_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
